// File: rtl/ssd1306_init_seq.sv
// SSD1306 power-up init sequencer feeding an I2C byte writer.
// Define SSD1306_INIT_CLEAR_EN to also clear display RAM after init.
module ssd1306_init_seq #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int PWRUP_MS  = 100,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       tx_done,
    input  logic       tx_nack,
    output logic       busy,
    output logic       init_done,
    output logic       init_err
);

    localparam int PWRUP_CYC = (CLK_HZ / 1000) * PWRUP_MS;
    localparam int WW = (PWRUP_CYC > 0) ? $clog2(PWRUP_CYC + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef SSD1306_INIT_CLEAR_EN
    localparam int IW = 11;
`else
    localparam int IW = 5;
`endif

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [2:0] {IDLE, PWRUP, SEND, WAIT_DONE, DONE, ERR} state_t;

    localparam logic [WW-1:0] WAIT_LAST =
        (PWRUP_CYC > 0) ? WW'(PWRUP_CYC - 1) : '0;
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);
    localparam logic [RW-1:0] RETRY_LAST =
        (MAX_RETRY > 0) ? RW'(MAX_RETRY - 1) : '0;
    localparam logic [RW-1:0] RETRY_ONE = RW'(1);
    localparam idx_t ONE    = idx_t'(1);
    localparam idx_t A_LAST = idx_t'(25);

    localparam logic [7:0] A_TBL [26] = '{
        8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
        8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
        8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4,
        8'hA6, 8'hAF
    };

    function automatic logic [7:0] a_byte(input idx_t i);
        return (i <= A_LAST) ? A_TBL[i[4:0]] : 8'h00;
    endfunction

`ifdef SSD1306_INIT_CLEAR_EN
    localparam idx_t B_LAST = idx_t'(6);
    localparam idx_t C_LAST = idx_t'(1024);
    localparam logic [7:0] B_TBL [7] = '{
        8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

    logic [1:0] txn;

    function automatic logic [7:0] byte_at(input logic [1:0] t, input idx_t i);
        case (t)
            2'd0:    return a_byte(i);
            2'd1:    return (i <= B_LAST) ? B_TBL[i[2:0]] : 8'h00;
            default: return (i == '0) ? 8'h40 : 8'h00;
        endcase
    endfunction

    function automatic idx_t last_at(input logic [1:0] t);
        case (t)
            2'd0:    return A_LAST;
            2'd1:    return B_LAST;
            default: return C_LAST;
        endcase
    endfunction
`endif

    state_t          state;
    logic [WW-1:0]   wait_cnt;
    logic [RW-1:0]   retry;
    idx_t            idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            retry     <= '0;
            idx       <= '0;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
`ifdef SSD1306_INIT_CLEAR_EN
            txn       <= 2'd0;
`endif
        end else begin
            case (state)
                PWRUP: begin
                    if (wait_cnt >= WAIT_LAST) begin
                        state   <= SEND;
                        idx     <= '0;
                        m_valid <= 1'b1;
                        m_data  <= A_TBL[0];
                        m_last  <= 1'b0;
`ifdef SSD1306_INIT_CLEAR_EN
                        txn     <= 2'd0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state   <= WAIT_DONE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_data  <= 8'h00;
                        end else begin
                            idx    <= idx + ONE;
`ifdef SSD1306_INIT_CLEAR_EN
                            m_data <= byte_at(txn, idx + ONE);
                            m_last <= (idx + ONE) == last_at(txn);
`else
                            m_data <= a_byte(idx + ONE);
                            m_last <= (idx + ONE) == A_LAST;
`endif
                        end
                    end
                end
                WAIT_DONE: begin
                    if (tx_done && !tx_nack) begin
`ifdef SSD1306_INIT_CLEAR_EN
                        if (txn != 2'd2) begin
                            state   <= SEND;
                            txn     <= txn + 2'd1;
                            idx     <= '0;
                            m_valid <= 1'b1;
                            m_data  <= (txn == 2'd0) ? B_TBL[0] : 8'h40;
                            m_last  <= 1'b0;
                        end else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            init_done <= 1'b1;
                        end
`else
                        state     <= DONE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
`endif
                    end else if (tx_done) begin
                        retry <= retry + RETRY_ONE;
                        if (retry >= RETRY_LAST) begin
                            state    <= ERR;
                            busy     <= 1'b0;
                            init_err <= 1'b1;
                        end else begin
                            // Any NACK restarts from the first init byte.
                            state   <= SEND;
                            idx     <= '0;
                            m_valid <= 1'b1;
                            m_data  <= A_TBL[0];
                            m_last  <= 1'b0;
`ifdef SSD1306_INIT_CLEAR_EN
                            txn     <= 2'd0;
`endif
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state     <= PWRUP;
                        wait_cnt  <= '0;
                        retry     <= '0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
